alu_encoder: RTL and testbench
==============================

ALU_ENCODER -- requirements
Module: alu_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  request valid.
REQ-004 in_ready  output  1  request slot available; transfer when in_valid && in_ready.
REQ-005 ctl  input  `ALU_CTL_WIDTH  ALU operation code (`ALU_* encodings).
REQ-006 mode  input  2  instruction class: 00 OP, 01 OP_IMM, 10 BRANCH, 11 reserved.
REQ-007 rd, rs1, rs2  input  5 each  register indices; rd ignored for BRANCH, rs2 ignored for OP_IMM.
REQ-008 imm  input  13  immediate: imm[11:0] for OP_IMM (imm[4:0] shamt for shifts), imm[12:1] branch offset.
REQ-009 out_valid  output  1  instruction word valid.
REQ-010 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-011 out_instr  output  32  encoded RV32I instruction.
REQ-012 err  output  1  one-cycle pulse, cycle after an illegal request is accepted.
REQ-013 err_count  output  8  illegal-request count (present only with ALU_ENC_ERR_CNT_EN).

Function
REQ-014 Request-to-opcode map: OP -> `RV32_OP, OP_IMM -> `RV32_OP_IMM, BRANCH -> `RV32_BRANCH.
REQ-015 OP/OP_IMM funct3: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111; funct7 0100000 for SUB/SRA, else 0000000.
REQ-016 BRANCH funct3: SEQ 000 (BEQ), SNE 001, SLT 100, SGE 101, SLTU 110, SGEU 111.
REQ-017 Formats: R {funct7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; shift-imm {funct7,imm[4:0],rs1,f3,rd,op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
REQ-018 Illegal: mode 11; SUB in OP_IMM; SEQ/SNE/SGE/SGEU/AUIPC in OP or OP_IMM; any non-comparison ctl in BRANCH; unknown ctl.
REQ-019 Illegal requests are accepted (in_ready unaffected), never enqueued, and raise err the following cycle.
REQ-020 Legal requests are encoded and written into a 2-entry FIFO; out_valid rises the cycle after acceptance into an empty FIFO (latency 1).
REQ-021 in_ready = FIFO occupancy < 2; occupancy 2 blocks input even if out_ready is high that cycle.
REQ-022 Simultaneous push and pop at occupancy 1: occupancy stays 1, order preserved.
REQ-023 out_instr and out_valid stable while out_valid && !out_ready.
REQ-024 Output order equals acceptance order of legal requests; pointers wrap modulo 2.
REQ-025 No combinational path from in_* to out_*.

Reset
REQ-026 rst asserted at any time, including mid-transfer: FIFO emptied, out_valid=0, err=0, err_count=0, in_ready=1 while rst is low after release; out_instr=0.
REQ-027 Outputs take reset values asynchronously on rst rising; first acceptance possible on first clk edge after rst falls.

Configuration
REQ-028 Macro ALU_ENC_ERR_CNT_EN defined: err_count port exists, increments once per illegal request, saturates at 255.
REQ-029 Macro ALU_ENC_ERR_CNT_EN undefined: err_count port and counter absent; err pulse behaviour unchanged.

Verification
REQ-030 OP, ctl=ALU_ADD, rd=3, rs1=1, rs2=2 -> out_instr 0x002081B3 one cycle later; same with ALU_SUB -> 0x402081B3.
REQ-031 OP_IMM, ALU_ADD, rd=5, rs1=0, imm=0xFFF -> 0xFFF00293; OP_IMM, ALU_SRA, rd=1, rs1=1, imm=3 -> 0x4030D093.
REQ-032 BRANCH, ALU_SEQ, rs1=1, rs2=2, imm=8 -> 0x00208463.
REQ-033 out_ready=0, three back-to-back legal requests -> in_ready low after second; raise out_ready -> words emerge in order, third accepted once a slot frees.
REQ-034 OP_IMM+ALU_SUB, then mode=11, then BRANCH+ALU_ADD -> three err pulses, nothing enqueued, err_count=3 (with macro); 300 illegal requests -> err_count=255.
REQ-035 rst pulsed with FIFO full and out_ready=0 -> out_valid drops immediately, err_count=0, in_ready=1 after release.

Source files
------------

// File: rtl/alu_encoder.sv
// alu_encoder: turns an ALU request (operation, instruction class, register
// indices, immediate) into an RV32I instruction word, buffered in a 2-entry
// FIFO with valid/ready handshakes on both sides. Illegal requests are
// accepted, dropped, and flagged with a one-cycle err pulse.
// Optional feature macro: ALU_ENC_ERR_CNT_EN adds the saturating 8-bit
// err_count output.

`ifndef ALU_CTL_WIDTH
`define ALU_CTL_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD   4'd0
`define ALU_SUB   4'd1
`define ALU_SLL   4'd2
`define ALU_SLT   4'd3
`define ALU_SLTU  4'd4
`define ALU_XOR   4'd5
`define ALU_SRL   4'd6
`define ALU_SRA   4'd7
`define ALU_OR    4'd8
`define ALU_AND   4'd9
`define ALU_SEQ   4'd10
`define ALU_SNE   4'd11
`define ALU_SGE   4'd12
`define ALU_SGEU  4'd13
`define ALU_AUIPC 4'd14
`endif
`ifndef RV32_OP
`define RV32_OP     7'b0110011
`define RV32_OP_IMM 7'b0010011
`define RV32_BRANCH 7'b1100011
`endif

module alu_encoder (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [`ALU_CTL_WIDTH-1:0] ctl,
  input  logic [1:0]                mode,
  input  logic [4:0]                rd,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  input  logic [12:0]               imm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instr,
  output logic                      err
`ifdef ALU_ENC_ERR_CNT_EN
  ,
  output logic [7:0]                err_count
`endif
);

  localparam logic [1:0] MODE_OP     = 2'b00;
  localparam logic [1:0] MODE_OP_IMM = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  logic [31:0] r_mem [2];
  logic        r_wrPtr;
  logic        r_rdPtr;
  logic [1:0]  r_count;
  logic        r_err;

  logic [2:0]  w_aluF3;
  logic [6:0]  w_aluF7;
  logic        w_aluOk;
  logic        w_immOk;
  logic        w_isShift;
  logic [2:0]  w_brF3;
  logic        w_brOk;
  logic        w_legal;
  logic [31:0] w_word;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  // Handshake flags depend only on registered occupancy, so there is no
  // combinational path from the request side to the output side.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_instr = out_valid ? r_mem[r_rdPtr] : 32'd0;
  assign err       = r_err;

  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = out_valid && out_ready;

  // Decode the ALU operation into funct3/funct7 for the OP/OP_IMM classes
  // and into a branch funct3 for comparison operations.
  always_comb begin
    w_aluF3   = 3'b000;
    w_aluF7   = 7'b0000000;
    w_aluOk   = 1'b1;
    w_immOk   = 1'b1;
    w_isShift = 1'b0;
    w_brF3    = 3'b000;
    w_brOk    = 1'b0;
    case (ctl)
      `ALU_ADD:  w_aluF3 = 3'b000;
      `ALU_SUB: begin
        w_aluF3 = 3'b000;
        w_aluF7 = 7'b0100000;
        w_immOk = 1'b0;
      end
      `ALU_SLL: begin
        w_aluF3   = 3'b001;
        w_isShift = 1'b1;
      end
      `ALU_SLT: begin
        w_aluF3 = 3'b010;
        w_brF3  = 3'b100;
        w_brOk  = 1'b1;
      end
      `ALU_SLTU: begin
        w_aluF3 = 3'b011;
        w_brF3  = 3'b110;
        w_brOk  = 1'b1;
      end
      `ALU_XOR:  w_aluF3 = 3'b100;
      `ALU_SRL: begin
        w_aluF3   = 3'b101;
        w_isShift = 1'b1;
      end
      `ALU_SRA: begin
        w_aluF3   = 3'b101;
        w_aluF7   = 7'b0100000;
        w_isShift = 1'b1;
      end
      `ALU_OR:   w_aluF3 = 3'b110;
      `ALU_AND:  w_aluF3 = 3'b111;
      `ALU_SEQ: begin
        w_aluOk = 1'b0;
        w_brF3  = 3'b000;
        w_brOk  = 1'b1;
      end
      `ALU_SNE: begin
        w_aluOk = 1'b0;
        w_brF3  = 3'b001;
        w_brOk  = 1'b1;
      end
      `ALU_SGE: begin
        w_aluOk = 1'b0;
        w_brF3  = 3'b101;
        w_brOk  = 1'b1;
      end
      `ALU_SGEU: begin
        w_aluOk = 1'b0;
        w_brF3  = 3'b111;
        w_brOk  = 1'b1;
      end
      default:   w_aluOk = 1'b0;
    endcase
  end

  // Assemble the instruction word for the selected class and decide legality.
  always_comb begin
    w_word  = 32'd0;
    w_legal = 1'b0;
    case (mode)
      MODE_OP: begin
        w_legal = w_aluOk;
        w_word  = {w_aluF7, rs2, rs1, w_aluF3, rd, `RV32_OP};
      end
      MODE_OP_IMM: begin
        w_legal = w_aluOk && w_immOk;
        if (w_isShift) begin
          w_word = {w_aluF7, imm[4:0], rs1, w_aluF3, rd, `RV32_OP_IMM};
        end else begin
          w_word = {imm[11:0], rs1, w_aluF3, rd, `RV32_OP_IMM};
        end
      end
      MODE_BRANCH: begin
        w_legal = w_brOk;
        w_word  = {imm[12], imm[10:5], rs2, rs1, w_brF3, imm[4:1], imm[11], `RV32_BRANCH};
      end
      default: begin
        w_legal = 1'b0;
        w_word  = 32'd0;
      end
    endcase
  end

  // FIFO storage; entries are only visible through out_instr while occupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_word;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_wrPtr <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle error pulse following acceptance of an illegal request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
    end
  end

`ifdef ALU_ENC_ERR_CNT_EN
  logic [7:0] r_errCount;

  assign err_count = r_errCount;

  // Saturating count of accepted illegal requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_errCount <= 8'd0;
    end else if (w_accept && !w_legal && (r_errCount != 8'hFF)) begin
      r_errCount <= r_errCount + 8'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_alu_encoder.sv
// Directed testbench for alu_encoder with hand-computed instruction words.
// Counter checks are compiled in only when ALU_ENC_ERR_CNT_EN is defined.

module tb_alu_encoder;

  localparam logic [3:0] C_ADD  = 4'd0;
  localparam logic [3:0] C_SUB  = 4'd1;
  localparam logic [3:0] C_SLL  = 4'd2;
  localparam logic [3:0] C_SRA  = 4'd7;
  localparam logic [3:0] C_SEQ  = 4'd10;
  localparam logic [3:0] C_SGEU = 4'd13;

  localparam logic [1:0] M_OP  = 2'b00;
  localparam logic [1:0] M_IMM = 2'b01;
  localparam logic [1:0] M_BR  = 2'b10;
  localparam logic [1:0] M_RSV = 2'b11;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [3:0]  ctl;
  logic [1:0]  mode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [12:0] imm;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstr;
  logic        err;
`ifdef ALU_ENC_ERR_CNT_EN
  logic [7:0]  errCount;
`endif

  int checks = 0;
  int failures = 0;

  alu_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .ctl       (ctl),
    .mode      (mode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_instr (outInstr),
    .err       (err)
`ifdef ALU_ENC_ERR_CNT_EN
    ,
    .err_count (errCount)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [3:0] c, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im);
    inValid = 1'b1;
    mode    = m;
    ctl     = c;
    rd      = d;
    rs1     = s1;
    rs2     = s2;
    imm     = im;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [3:0] c, input logic [4:0] d,
                               input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im);
    drive(m, c, d, s1, s2, im);
    tick();
    inValid = 1'b0;
  endtask

  task automatic popOne();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  task automatic encodeAndPop(input string tag, input logic [1:0] m, input logic [3:0] c,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [12:0] im, input logic [31:0] expected);
    applyStimulus(m, c, d, s1, s2, im);
    checkOutput({tag, "_valid"}, {31'd0, outValid}, 32'd1);
    checkOutput(tag, outInstr, expected);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
    popOne();
    checkOutput({tag, "_drain"}, {31'd0, outValid}, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    ctl      = 4'd0;
    mode     = 2'd0;
    rd       = 5'd0;
    rs1      = 5'd0;
    rs2      = 5'd0;
    imm      = 13'd0;

    #3;
    checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst_out_instr", outInstr, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_in_ready", {31'd0, inReady}, 32'd1);

    encodeAndPop("op_add",  M_OP,  C_ADD,  5'd3, 5'd1, 5'd2, 13'd0,     32'h002081B3);
    encodeAndPop("op_sub",  M_OP,  C_SUB,  5'd3, 5'd1, 5'd2, 13'd0,     32'h402081B3);
    encodeAndPop("imm_add", M_IMM, C_ADD,  5'd5, 5'd0, 5'd9, 13'h0FFF,  32'hFFF00293);
    encodeAndPop("imm_sra", M_IMM, C_SRA,  5'd1, 5'd1, 5'd0, 13'd3,     32'h4030D093);
    encodeAndPop("imm_sll", M_IMM, C_SLL,  5'd2, 5'd3, 5'd0, 13'd5,     32'h00519113);
    encodeAndPop("br_beq",  M_BR,  C_SEQ,  5'd7, 5'd1, 5'd2, 13'd8,     32'h00208463);
    encodeAndPop("br_bgeu", M_BR,  C_SGEU, 5'd0, 5'd4, 5'd5, 13'h1FFC,  32'hFE527EE3);

    // Backpressure: fill both slots, third request waits until a slot frees.
    applyStimulus(M_OP, C_ADD, 5'd3, 5'd1, 5'd2, 13'd0);
    checkOutput("bp_ready_after1", {31'd0, inReady}, 32'd1);
    applyStimulus(M_OP, C_SUB, 5'd3, 5'd1, 5'd2, 13'd0);
    checkOutput("bp_ready_after2", {31'd0, inReady}, 32'd0);
    drive(M_IMM, C_ADD, 5'd5, 5'd0, 5'd0, 13'h0FFF);
    tick();
    checkOutput("bp_hold_first", outInstr, 32'h002081B3);
    checkOutput("bp_still_full", {31'd0, inReady}, 32'd0);
    outReady = 1'b1;
    tick();
    checkOutput("bp_second_word", outInstr, 32'h402081B3);
    checkOutput("bp_slot_free", {31'd0, inReady}, 32'd1);
    tick();
    inValid = 1'b0;
    checkOutput("bp_third_word", outInstr, 32'hFFF00293);
    checkOutput("bp_third_valid", {31'd0, outValid}, 32'd1);
    tick();
    outReady = 1'b0;
    checkOutput("bp_drained", {31'd0, outValid}, 32'd0);

    // Illegal requests: err pulses, nothing enqueued.
    applyStimulus(M_IMM, C_SUB, 5'd1, 5'd1, 5'd1, 13'd0);
    checkOutput("ill_imm_sub_err", {31'd0, err}, 32'd1);
    checkOutput("ill_imm_sub_noq", {31'd0, outValid}, 32'd0);
    applyStimulus(M_RSV, C_ADD, 5'd1, 5'd1, 5'd1, 13'd0);
    checkOutput("ill_mode3_err", {31'd0, err}, 32'd1);
    applyStimulus(M_BR, C_ADD, 5'd1, 5'd1, 5'd1, 13'd0);
    checkOutput("ill_br_add_err", {31'd0, err}, 32'd1);
    checkOutput("ill_noq", {31'd0, outValid}, 32'd0);
`ifdef ALU_ENC_ERR_CNT_EN
    checkOutput("err_count_3", {24'd0, errCount}, 32'd3);
`endif
    tick();
    checkOutput("err_pulse_ends", {31'd0, err}, 32'd0);
    applyStimulus(M_OP, C_SEQ, 5'd1, 5'd1, 5'd1, 13'd0);
    checkOutput("ill_op_seq_err", {31'd0, err}, 32'd1);
    checkOutput("ill_op_seq_noq", {31'd0, outValid}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(M_RSV, C_ADD, 5'd0, 5'd0, 5'd0, 13'd0);
    end
`ifdef ALU_ENC_ERR_CNT_EN
    checkOutput("err_count_sat", {24'd0, errCount}, 32'd255);
`endif
    tick();

    // Reset with the FIFO full and the consumer stalled.
    applyStimulus(M_OP, C_ADD, 5'd3, 5'd1, 5'd2, 13'd0);
    applyStimulus(M_OP, C_SUB, 5'd3, 5'd1, 5'd2, 13'd0);
    checkOutput("full_before_rst", {31'd0, inReady}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst_async_instr", outInstr, 32'd0);
`ifdef ALU_ENC_ERR_CNT_EN
    checkOutput("rst_err_count", {24'd0, errCount}, 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post_rst_ready", {31'd0, inReady}, 32'd1);
    checkOutput("post_rst_valid", {31'd0, outValid}, 32'd0);
    encodeAndPop("post_rst_add", M_OP, C_ADD, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
